// File: rtl/binary_entry_pkg.sv
// Shared types and ASCII constants for the binary entry controller.
package binary_entry_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PROMPT    = 3'd1,
    GET_DIGIT = 3'd2,
    GET_NL    = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'd48;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

endpackage

// File: rtl/ascii_bit_decode.sv
// Combinational ASCII-to-digit decode: v = char - '0' (8-bit wrap), is_bit = (v <= 1).
module ascii_bit_decode
  import binary_entry_pkg::*;
(
  input  logic [7:0] i_char_data,
  output logic [7:0] o_v,
  output logic       o_is_bit
);

  // Bytes below '0' wrap to large values and therefore never decode as a bit
  assign o_v      = i_char_data - ASCII_ZERO;
  assign o_is_bit = (o_v <= 8'd1);

endmodule

// File: rtl/binary_entry_ctrl.sv
// Console-style binary entry sequencer: prompt, take one digit, drop the
// line terminator, shift digits MSB-first into a WIDTH-bit word.
// Optional macro STRICT_NEWLINE_EN: only LF/CR are accepted as terminators;
// anything else raises err and ends the session.
module binary_entry_ctrl
  import binary_entry_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_char_valid,
  input  logic [7:0]       i_char_data,
  output logic             o_char_ready,
  output logic             o_prompt,
  output logic             o_bit_valid,
  output logic             o_bit_value,
  output logic [WIDTH-1:0] o_word,
  output logic             o_word_valid,
  output logic [CW-1:0]    o_bit_count,
  output logic             o_done,
  output logic             o_err
);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_word, w_word_nxt;
  logic               r_prompt, w_prompt_nxt;
  logic               r_bit_valid, w_bit_valid_nxt;
  logic               r_bit_value, w_bit_value_nxt;
  logic               r_word_valid, w_word_valid_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;

  logic [7:0]         w_v;
  logic               w_is_bit;
  logic               w_xfer;
  logic               w_unused_v;

  ascii_bit_decode u_decode (
    .i_char_data (i_char_data),
    .o_v         (w_v),
    .o_is_bit    (w_is_bit)
  );

  // Only bit 0 of the decoded value feeds the accumulator
  assign w_unused_v = ^w_v[7:1];

  // Byte acceptance is purely a function of state
  assign o_char_ready = (r_state == GET_DIGIT) || (r_state == GET_NL);
  assign w_xfer       = i_char_valid && o_char_ready;

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_prompt     <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_bit_value  <= 1'b0;
      r_word_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_word       <= w_word_nxt;
      r_prompt     <= w_prompt_nxt;
      r_bit_valid  <= w_bit_valid_nxt;
      r_bit_value  <= w_bit_value_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Next-state and next-output logic; pulses default low, levels hold
  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_cnt_nxt        = r_cnt;
    w_word_nxt       = r_word;
    w_prompt_nxt     = 1'b0;
    w_bit_valid_nxt  = 1'b0;
    w_bit_value_nxt  = r_bit_value;
    w_word_valid_nxt = 1'b0;
    w_done_nxt       = r_done;
    w_err_nxt        = r_err;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt  = PROMPT;
          w_prompt_nxt = 1'b1;
        end
      end

      PROMPT: begin
        w_state_nxt = GET_DIGIT;
      end

      GET_DIGIT: begin
        if (w_xfer) begin
          if (w_is_bit) begin
            w_acc_nxt       = {r_acc[WIDTH-2:0], w_v[0]};
            w_cnt_nxt       = r_cnt + CW'(1);
            w_bit_valid_nxt = 1'b1;
            w_bit_value_nxt = w_v[0];
            w_state_nxt     = GET_NL;
          end else begin
            // Non-digit ends the session, flushing any partial word
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            if (r_cnt != '0) begin
              w_word_valid_nxt = 1'b1;
              w_word_nxt       = r_acc;
            end
          end
        end
      end

      GET_NL: begin
        if (w_xfer) begin
`ifdef STRICT_NEWLINE_EN
          if ((i_char_data != ASCII_LF) && (i_char_data != ASCII_CR)) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
            if (r_cnt != '0) begin
              w_word_valid_nxt = 1'b1;
              w_word_nxt       = r_acc;
            end
          end else begin
`endif
            if (r_cnt == CW'(WIDTH)) begin
              w_word_valid_nxt = 1'b1;
              w_word_nxt       = r_acc;
              w_acc_nxt        = '0;
              w_cnt_nxt        = '0;
            end
            w_state_nxt  = PROMPT;
            w_prompt_nxt = 1'b1;
`ifdef STRICT_NEWLINE_EN
          end
`endif
        end
      end

      DONE: begin
        if (i_start) begin
          w_done_nxt   = 1'b0;
          w_err_nxt    = 1'b0;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = PROMPT;
          w_prompt_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_prompt     = r_prompt;
  assign o_bit_valid  = r_bit_valid;
  assign o_bit_value  = r_bit_value;
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_bit_count  = r_cnt;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: doc/binary_entry_ctrl.md
Name: binary_entry_ctrl

Overview:
- Synthesizable controller that sequences console-style binary entry over a byte-stream handshake.
- Prompts for a digit, accepts one ASCII character, converts it by subtracting 48, and shifts '0'/'1' into an accumulator.
- Discards the following line-terminator byte; any other character ends the session.
- Sits between a character source (UART RX / stdin model) and downstream logic consuming assembled words.

Parameters:
- WIDTH, 8, bits per assembled word; must be ≥ 2.
- CW, $clog2(WIDTH+1), width of bit_count (derived; do not override).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a session; honoured only in IDLE or DONE.
- char_valid  in  1  source has a byte.
- char_data  in  8  ASCII byte.
- char_ready  out  1  controller accepts a byte; a transfer occurs when char_valid && char_ready at a rising edge.
- prompt  out  1  one-cycle pulse; "enter binary" request.
- bit_valid  out  1  one-cycle pulse; a digit was accepted.
- bit_value  out  1  accepted digit; valid with bit_valid.
- word  out  WIDTH  assembled word; valid with word_valid, held otherwise.
- word_valid  out  1  one-cycle pulse.
- bit_count  out  CW  bits in the current partial word.
- done  out  1  session ended; level, held until start or reset.
- err  out  1  framing error; level, constant 0 unless the optional feature is compiled in.

Behaviour:
- Reset: all outputs 0, accumulator 0, bit_count 0, state IDLE. rst_n low at any edge, in any state, discards partial data.
- States: IDLE, PROMPT, GET_DIGIT, GET_NL, DONE.
- char_ready: combinational; 1 only in GET_DIGIT and GET_NL. Bytes presented in other states are not consumed.
- IDLE: on start, go to PROMPT.
- PROMPT: lasts one cycle; prompt=1 during that cycle; then go to GET_DIGIT.
- GET_DIGIT, on transfer:
  - Compute v = char_data - 8'd48 as 8-bit unsigned with wrap, so bytes below '0' become large.
  - If v ≤ 1: acc <= {acc[WIDTH-2:0], v[0]} (MSB-first); bit_count++; next cycle bit_valid=1, bit_value=v[0]; go to GET_NL.
  - If v > 1: go to DONE; done=1 from the next cycle.
    - If bit_count>0: word_valid pulses with word = acc (partial, right-aligned).
    - If bit_count==0: no word_valid.
- GET_NL, on transfer: byte discarded, whatever its value (see optional feature).
  - If bit_count==WIDTH: word_valid pulses with word=acc; acc and bit_count clear to 0.
  - Then go to PROMPT.
- DONE: char_ready=0.
  - On start: clear done, err, acc, bit_count; go to PROMPT.
- start is ignored in PROMPT, GET_DIGIT and GET_NL.
- Timing of pulses: prompt, bit_valid and word_valid are registered, appear in the cycle after the causing edge, and last exactly one cycle. word holds its last value between pulses.
- Throughput: one character per cycle is possible in GET_DIGIT/GET_NL; each digit costs at minimum PROMPT + 2 transfers = 3 cycles.
- Simultaneous events:
  - Reset overrides start and any transfer.
  - A transfer and start in the same cycle cannot conflict, because char_ready=0 wherever start is honoured.

Optional Feature:
- Macro: STRICT_NEWLINE_EN.
- Defined: GET_NL accepts only 8'h0A or 8'h0D.
  - Any other byte sets err=1 and goes to DONE.
  - word_valid pulses with acc if bit_count>0.
- Undefined: any byte in GET_NL is discarded silently; err tied to 0.

Decomposition:
- Package binary_entry_pkg holds:
  - state enum type state_t (IDLE, PROMPT, GET_DIGIT, GET_NL, DONE);
  - ASCII_ZERO = 8'd48;
  - ASCII_LF = 8'h0A;
  - ASCII_CR = 8'h0D.
- One natural sub-module: ascii_bit_decode, combinational, char_data -> (v[7:0], is_bit = v ≤ 1). Instantiated once in GET_DIGIT decode.

Test Plan:
- Reset, start, feed '1',LF,'0',LF,'1',LF,'x'(0x78) -> 4 prompt pulses; bit_value 1,0,1; then word_valid with word=8'h05, bit_count=3, done=1, char_ready=0.
- Feed 8 digits "10110010", each followed by LF -> word_valid with word=8'hB2 after the 8th LF; bit_count=0; next prompt pulses and the session continues.
- Start, feed ' ' (0x20; 0x20-0x30 wraps to 0xF0) -> done=1 next cycle; no word_valid; bit_count=0.
- After 3 bits accepted, assert rst_n=0 for one edge while in GET_NL -> next cycle state IDLE; all outputs 0; char_ready=0; following start yields a fresh prompt with bit_count=0.
- Hold char_valid=1 with 0x31 in IDLE and PROMPT -> no consumption, no bit_valid. Pulse start while in GET_DIGIT -> ignored, no extra prompt.
- With STRICT_NEWLINE_EN: feed '1' then 'A' (0x41) -> err=1, done=1, word_valid with word=8'h01. Without the macro: same stimulus -> 'A' discarded, next prompt pulses, err=0.
